sync_fifo_lvl: RTL and testbench

SYNC_FIFO_LVL -- requirements
Module: sync_fifo_lvl

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/fifo_ptr.sv | 33 +++
 rtl/sync_fifo_lvl.sv | 113 +++++++++++
 tb/tb_sync_fifo_lvl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared widths and pointer type for the level-tracking synchronous FIFO.
package sync_fifo_pkg;

  localparam int MAX_PTR_W = 32;

  // Pointer index plus wrap round bit; index is wide enough for any DEPTH.
  typedef struct packed {
    logic                 rnd;
    logic [MAX_PTR_W-1:0] idx;
  } ptr_rnd_t;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer: wraps DEPTH-1 -> 0 and toggles its round bit on each wrap.
module fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_clr,
  input  logic     i_adv,
  output ptr_rnd_t o_ptr
);

  ptr_rnd_t r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      if (r_ptr.idx == 32'(DEPTH - 1)) begin
        r_ptr.idx <= '0;
        r_ptr.rnd <= ~r_ptr.rnd;
      end else begin
        r_ptr.idx <= r_ptr.idx + 32'd1;
      end
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_lvl.sv
// First-word-fall-through synchronous FIFO with occupancy level and thresholds.
// Define SYNC_FIFO_PEAK_EN to add the peak_level high-water-mark output.
module sync_fifo_lvl
  import sync_fifo_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 4,
  parameter  int AF_THRESH = DEPTH - 1,
  parameter  int AE_THRESH = 1,
  localparam int PTR_W     = ptr_w(DEPTH),
  localparam int LVL_W     = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [LVL_W-1:0] level,
  output logic             almost_full,
  output logic             almost_empty
`ifdef SYNC_FIFO_PEAK_EN
  ,
  output logic [LVL_W-1:0] peak_level
`endif
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_lvl_nxt;
  ptr_rnd_t         w_wr_ptr;
  ptr_rnd_t         w_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_hs;
  logic             w_rd_hs;

  // Ready/valid come from pointer state only, so full drains before refilling.
  assign w_full  = (w_wr_ptr.idx == w_rd_ptr.idx) && (w_wr_ptr.rnd != w_rd_ptr.rnd);
  assign w_empty = (w_wr_ptr.idx == w_rd_ptr.idx) && (w_wr_ptr.rnd == w_rd_ptr.rnd);
  assign s_ready = ~w_full;
  assign m_valid = ~w_empty;
  assign w_wr_hs = s_valid & s_ready;
  assign w_rd_hs = m_valid & m_ready;

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush),
    .i_adv (w_wr_hs),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush),
    .i_adv (w_rd_hs),
    .o_ptr (w_rd_ptr)
  );

  // Storage is never cleared; flush and reset only drop the write.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_wr_hs) begin
      r_mem[w_wr_ptr.idx[PTR_W-1:0]] <= s_data;
    end
  end

  assign m_data = r_mem[w_rd_ptr.idx[PTR_W-1:0]];

  always_comb begin
    w_lvl_nxt = r_level;
    if (w_wr_hs && !w_rd_hs) begin
      w_lvl_nxt = r_level + LVL_W'(1);
    end else if (!w_wr_hs && w_rd_hs) begin
      w_lvl_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (flush) begin
      r_level <= '0;
    end else begin
      r_level <= w_lvl_nxt;
    end
  end

  assign level        = r_level;
  assign almost_full  = (32'(r_level) >= 32'(AF_THRESH));
  assign almost_empty = (32'(r_level) <= 32'(AE_THRESH));

`ifdef SYNC_FIFO_PEAK_EN
  logic [LVL_W-1:0] r_peak;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (flush) begin
      r_peak <= '0;
    end else if (w_lvl_nxt > r_peak) begin
      r_peak <= w_lvl_nxt;
    end
  end

  assign peak_level = r_peak;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl (DEPTH=5, WIDTH=16) with a queue-based reference model.
module tb_sync_fifo_lvl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [LVL_W-1:0] level;
  logic             almost_full;
  logic             almost_empty;
`ifdef SYNC_FIFO_PEAK_EN
  logic [LVL_W-1:0] peak_level;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  sync_fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef SYNC_FIFO_PEAK_EN
    ,
    .peak_level   (peak_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: contents as a plain queue, updated from the inputs seen at each edge.
  logic [WIDTH-1:0] mq[$];
  int  mpeak  = 0;
  bit  mdl_on = 1'b0;

  always @(posedge clk) begin
    bit wr, rd;
    if (!rst_n || flush) begin
      mq.delete();
      mpeak = 0;
    end else begin
      wr = s_valid && (mq.size() < DEPTH);
      rd = m_ready && (mq.size() > 0);
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(s_data);
      if (mq.size() > mpeak) mpeak = mq.size();
    end
    mdl_on = 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("mdl_level",   32'(level),        32'(mq.size()));
      chk("mdl_s_ready", 32'(s_ready),      32'(mq.size() < DEPTH));
      chk("mdl_m_valid", 32'(m_valid),      32'(mq.size() > 0));
      chk("mdl_afull",   32'(almost_full),  32'(mq.size() >= AF));
      chk("mdl_aempty",  32'(almost_empty), 32'(mq.size() <= AE));
      if (mq.size() > 0) chk("mdl_m_data", 32'(m_data), 32'(mq[0]));
`ifdef SYNC_FIFO_PEAK_EN
      chk("mdl_peak", 32'(peak_level), 32'(mpeak));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_n(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + WIDTH'(i);
      step();
    end
    s_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] got[$];

  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    chk("rst_level",  32'(level),        0);
    chk("rst_s_ready",32'(s_ready),      1);
    chk("rst_m_valid",32'(m_valid),      0);
    chk("rst_afull",  32'(almost_full),  0);
    chk("rst_aempty", 32'(almost_empty), 1);

    // Fill to full, then offer a sixth word
    wr_n(5, 16'h0001);
    chk("fill_level",  32'(level),       5);
    chk("fill_s_ready",32'(s_ready),     0);
    chk("fill_afull",  32'(almost_full), 1);
    s_valid = 1'b1; s_data = 16'h0006;
    step();
    s_valid = 1'b0;
    chk("sixth_level", 32'(level), 5);

    // Drain in order
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("drain_m_valid", 32'(m_valid), 1);
      chk("drain_m_data",  32'(m_data),  32'(i));
      step();
    end
    m_ready = 1'b0;
    chk("drain_m_valid_end", 32'(m_valid),      0);
    chk("drain_level_end",   32'(level),        0);
    chk("drain_aempty_end",  32'(almost_empty), 1);

    // Continuous writes with reads starting two cycles later, across pointer wrap
    for (int c = 0; c < 16; c++) begin
      s_valid = (c < 12);
      s_data  = 16'h0100 + WIDTH'(c);
      m_ready = (c >= 2);
      if (m_valid && m_ready) got.push_back(m_data);
      step();
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("stream_count", 32'(got.size()), 12);
    for (int k = 0; k < got.size(); k++) chk("stream_data", 32'(got[k]), 32'h100 + 32'(k));
    chk("stream_level_end", 32'(level), 0);

    // Full with read and write offered together: read only, then write
    wr_n(5, 16'h0201);
    s_valid = 1'b1; s_data = 16'h02AA; m_ready = 1'b1;
    chk("fullrw_s_ready_pre", 32'(s_ready), 0);
    step();
    chk("fullrw_level_4",   32'(level),   4);
    chk("fullrw_s_ready_1", 32'(s_ready), 1);
    m_ready = 1'b0;
    step();
    s_valid = 1'b0;
    chk("fullrw_level_5", 32'(level), 5);
    m_ready = 1'b1;
    repeat (5) step();
    m_ready = 1'b0;
    chk("fullrw_level_end", 32'(level), 0);

    // Flush at level 3 with both handshakes offered
    wr_n(3, 16'h0031);
    chk("pre_flush_level", 32'(level), 3);
    flush = 1'b1; s_valid = 1'b1; s_data = 16'h003F; m_ready = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    chk("flush_level",   32'(level),   0);
    chk("flush_m_valid", 32'(m_valid), 0);
`ifdef SYNC_FIFO_PEAK_EN
    chk("flush_peak", 32'(peak_level), 0);
`endif

    // Reset at level 3 with both handshakes offered
    wr_n(3, 16'h0051);
    rst_n = 1'b0; s_valid = 1'b1; s_data = 16'h005F; m_ready = 1'b1;
    step();
    rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    chk("mrst_level",   32'(level),   0);
    chk("mrst_m_valid", 32'(m_valid), 0);
`ifdef SYNC_FIFO_PEAK_EN
    chk("mrst_peak", 32'(peak_level), 0);
`endif
    wr_n(1, 16'h0077);
    chk("post_rst_m_data", 32'(m_data), 32'h77);
    chk("post_rst_level",  32'(level),  1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;

    // High-water mark: write 4, read 3, write 1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wr_n(4, 16'h0041);
    m_ready = 1'b1;
    repeat (3) step();
    m_ready = 1'b0;
    wr_n(1, 16'h0045);
    chk("peakseq_level",  32'(level),  2);
    chk("peakseq_m_data", 32'(m_data), 32'h44);
`ifdef SYNC_FIFO_PEAK_EN
    chk("peakseq_peak", 32'(peak_level), 4);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
